// File: rtl/rendering_bbox_pixel_scan.sv
// rtl/rendering_bbox_pixel_scan.sv - row-major bounding-box pixel walker with linear address
// Accepts one box, then emits (x, y, y*pitch+x) beats over a valid/ready stream.
module rendering_bbox_pixel_scan #(
    parameter int COORD_W = 8,
    parameter int PITCH_W = 10,
    parameter int ADDR_W  = 17
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [PITCH_W-1:0] pitch,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_xmin,
    input  logic [COORD_W-1:0] in_xmax,
    input  logic [COORD_W-1:0] in_ymin,
    input  logic [COORD_W-1:0] in_ymax,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               out_last,
    output logic               err_empty
);

    localparam int PROD_W = COORD_W + PITCH_W;

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
    logic [PITCH_W-1:0] pitch_q, pitch_d;
    logic [ADDR_W-1:0]  row_q, row_d, addr_q, addr_d;
    logic               err_q, err_d;

    logic [COORD_W-1:0] mul_y;
    logic [PITCH_W-1:0] mul_p;
    logic [ADDR_W-1:0]  row_calc;
    logic               at_xmax, at_ymax, box_empty;

    // One shared multiplier: first row of a new box, or the next row during a scan.
    assign mul_y    = (state_q == S_IDLE) ? in_ymin : (y_q + COORD_W'(1));
    assign mul_p    = (state_q == S_IDLE) ? pitch   : pitch_q;
    assign row_calc = ADDR_W'({{PITCH_W{1'b0}}, mul_y} * {{COORD_W{1'b0}}, mul_p});

    assign at_xmax   = (x_q == xmax_q);
    assign at_ymax   = (y_q == ymax_q);
    assign box_empty = (in_xmin > in_xmax) || (in_ymin > in_ymax);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymax_d  = ymax_q;
        pitch_d = pitch_q;
        row_d   = row_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    pitch_d = pitch;
                    xmin_d  = in_xmin;
                    xmax_d  = in_xmax;
                    ymax_d  = in_ymax;
                    if (box_empty) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_SCAN;
                        x_d     = in_xmin;
                        y_d     = in_ymin;
                        row_d   = row_calc;
                        addr_d  = row_calc + ADDR_W'(in_xmin);
                    end
                end
            end
            S_SCAN: begin
                // Equality tests happen before any increment, so 255 never wraps.
                if (out_ready) begin
                    if (!at_xmax) begin
                        x_d    = x_q + COORD_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                    end else if (!at_ymax) begin
                        x_d    = xmin_q;
                        y_d    = y_q + COORD_W'(1);
                        row_d  = row_calc;
                        addr_d = row_calc + ADDR_W'(xmin_q);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            pitch_q <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymax_q  <= ymax_d;
            pitch_q <= pitch_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_SCAN);
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_addr  = addr_q;
    assign out_last  = (state_q == S_SCAN) && at_xmax && at_ymax;
    assign err_empty = err_q;

endmodule

// File: tb/tb_rendering_bbox_pixel_scan.sv
// tb/tb_rendering_bbox_pixel_scan.sv - self-checking bench for the bbox pixel scanner
// A box-level model expands each accepted box into its expected beat list.
module tb_rendering_bbox_pixel_scan;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [9:0]  pitch = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_xmin = '0, in_xmax = '0, in_ymin = '0, in_ymax = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_x, out_y;
    logic [16:0] out_addr;
    logic        out_last;
    logic        err_empty;

    rendering_bbox_pixel_scan dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .pitch(pitch),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_xmin(in_xmin), .in_xmax(in_xmax), .in_ymin(in_ymin), .in_ymax(in_ymax),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_addr(out_addr), .out_last(out_last),
        .err_empty(err_empty)
    );

    initial forever #5 ap_clk = ~ap_clk;

    typedef struct {
        int x;
        int y;
        int addr;
        bit last;
    } beat_t;

    beat_t q[$];
    beat_t obs[$];
    int    n_pass = 0;
    int    n_total = 0;
    int    n_err = 0;
    bit    err_pend = 1'b0;
    bit    rdy_rand = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Expected beat list derived straight from the box definition.
    task automatic model_box(input int xmn, input int xmx, input int ymn, input int ymx, input int p);
        for (int y = ymn; y <= ymx; y++)
            for (int x = xmn; x <= xmx; x++) begin
                beat_t b;
                b.x = x;
                b.y = y;
                b.addr = (y * p + x) % (1 << 17);
                b.last = (x == xmx) && (y == ymx);
                q.push_back(b);
            end
    endtask

    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_out_last", int'(out_last), 0);
            chk("rst_err_empty", int'(err_empty), 0);
            chk("rst_out_x", int'(out_x), 0);
            chk("rst_out_y", int'(out_y), 0);
            chk("rst_out_addr", int'(out_addr), 0);
            q.delete();
            err_pend = 1'b0;
        end else begin
            chk("err_empty", int'(err_empty), int'(err_pend));
            if (err_empty) n_err++;
            chk("out_valid", int'(out_valid), int'(q.size() != 0));
            chk("in_ready", int'(in_ready), int'(q.size() == 0));
            if (out_valid && q.size() != 0) begin
                chk("out_x", int'(out_x), q[0].x);
                chk("out_y", int'(out_y), q[0].y);
                chk("out_addr", int'(out_addr), q[0].addr);
                chk("out_last", int'(out_last), int'(q[0].last));
                if (out_ready) begin
                    beat_t b;
                    b.x = int'(out_x);
                    b.y = int'(out_y);
                    b.addr = int'(out_addr);
                    b.last = out_last;
                    obs.push_back(b);
                    void'(q.pop_front());
                end
            end
            err_pend = 1'b0;
            if (in_valid && in_ready) begin
                if (in_xmin > in_xmax || in_ymin > in_ymax) err_pend = 1'b1;
                else model_box(int'(in_xmin), int'(in_xmax), int'(in_ymin), int'(in_ymax), int'(pitch));
            end
        end
    end

    initial forever begin
        @(posedge ap_clk);
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send_box(input int xmn, input int xmx, input int ymn, input int ymx, input int p);
        int cyc = 0;
        bit done = 1'b0;
        in_xmin = 8'(xmn);
        in_xmax = 8'(xmx);
        in_ymin = 8'(ymn);
        in_ymax = 8'(ymx);
        pitch = 10'(p);
        in_valid = 1'b1;
        while (!done && cyc < 2000) begin
            done = in_ready;
            @(posedge ap_clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("accept_timeout", int'(done), 1);
    endtask

    task automatic wait_idle();
        int cyc = 0;
        @(negedge ap_clk);
        while (!(in_ready && q.size() == 0) && cyc < 5000) begin
            @(negedge ap_clk);
            cyc++;
        end
        chk("idle_timeout", int'(cyc < 5000), 1);
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        int t1_addr[6];
        int e0;
        t1_addr = '{258, 259, 260, 514, 515, 516};
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;

        // T1: basic 3x2 box
        obs.delete();
        send_box(2, 4, 1, 2, 256);
        wait_idle();
        chk("t1_beats", obs.size(), 6);
        for (int i = 0; i < 6 && i < obs.size(); i++) begin
            chk("t1_addr", obs[i].addr, t1_addr[i]);
            chk("t1_last", int'(obs[i].last), int'(i == 5));
        end

        // T2: stall mid-stream, poke inputs during scan
        obs.delete();
        send_box(7, 7, 7, 9, 100);
        @(posedge ap_clk);
        #1 out_ready = 1'b0;
        pitch = 10'd5;
        in_xmin = 8'd0;
        repeat (3) @(posedge ap_clk);
        #1 out_ready = 1'b1;
        wait_idle();
        chk("t2_beats", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("t2_last_x", obs[2].x, 7);
            chk("t2_last_y", obs[2].y, 9);
            chk("t2_last_flag", int'(obs[2].last), 1);
            chk("t2_mid_addr", obs[1].addr, 807);
        end

        // T3: coordinate ceiling and address truncation
        obs.delete();
        send_box(255, 255, 254, 255, 1023);
        wait_idle();
        chk("t3_beats", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("t3_addr0", obs[0].addr, 129025);
            chk("t3_addr1", obs[1].addr, 130048);
            chk("t3_y1", obs[1].y, 255);
        end

        // T4: empty box
        obs.delete();
        e0 = n_err;
        send_box(5, 3, 0, 0, 10);
        repeat (4) @(posedge ap_clk);
        #1;
        chk("t4_err_pulses", n_err - e0, 1);
        chk("t4_beats", obs.size(), 0);
        chk("t4_in_ready", int'(in_ready), 1);

        // T5: reset on third beat of a 4x4 box
        send_box(0, 3, 0, 3, 16);
        @(posedge ap_clk);
        #1;
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        #1;
        chk("t5_valid_drop", int'(out_valid), 0);
        chk("t5_addr_zero", int'(out_addr), 0);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        obs.delete();
        send_box(10, 11, 20, 20, 50);
        wait_idle();
        chk("t5_beats", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("t5_first_x", obs[0].x, 10);
            chk("t5_first_y", obs[0].y, 20);
            chk("t5_first_addr", obs[0].addr, 1010);
        end

        // T6: random boxes with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            int xa, ya, xb, yb;
            xa = $urandom_range(0, 255);
            ya = $urandom_range(0, 255);
            xb = xa + $urandom_range(0, 4);
            yb = ya + $urandom_range(0, 3);
            if (xb > 255) xb = 255;
            if (yb > 255) yb = 255;
            if ($urandom_range(0, 7) == 0) begin
                int t;
                t = xa; xa = xb; xb = t - 1;
                if (xb < 0) xb = 0;
            end
            send_box(xa, xb, ya, yb, $urandom_range(0, 1023));
            wait_idle();
        end
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge ap_clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
